// File: rtl/otter_decode_queue_if.sv
// Fetch-to-execute handshake bundle for otter_decode_queue: instruction input side
// and decoded control-word output side.
interface otter_decode_queue_if #(parameter int XLEN = 32);
  logic            IN_VALID;
  logic            IN_READY;
  logic [31:0]     IN_IR;
  logic [XLEN-1:0] IN_PC;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [3:0]      ALU_FUN;
  logic            ALU_SRCA;
  logic [1:0]      ALU_SRCB;
  logic [1:0]      RF_WR_SEL;
  logic            REG_WE;
  logic            MEM_WE;
  logic            MEM_RDEN;
  logic [1:0]      PC_SEL;
  logic            ILLEGAL;
  logic [31:0]     OUT_IR;
  logic [XLEN-1:0] OUT_PC;

  modport slave (
    input  IN_VALID, IN_IR, IN_PC, OUT_READY,
    output IN_READY, OUT_VALID, ALU_FUN, ALU_SRCA, ALU_SRCB, RF_WR_SEL,
           REG_WE, MEM_WE, MEM_RDEN, PC_SEL, ILLEGAL, OUT_IR, OUT_PC
  );

  modport master (
    output IN_VALID, IN_IR, IN_PC, OUT_READY,
    input  IN_READY, OUT_VALID, ALU_FUN, ALU_SRCA, ALU_SRCB, RF_WR_SEL,
           REG_WE, MEM_WE, MEM_RDEN, PC_SEL, ILLEGAL, OUT_IR, OUT_PC
  );
endinterface

// File: rtl/otter_decode_queue.sv
// RV32I decode stage with a DEPTH-entry FIFO of decoded control words.
// Optional macro DECODE_STATS_EN adds STAT_DEC/STAT_ILL push counters.
module otter_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic FLUSH,
`ifdef DECODE_STATS_EN
  output logic [31:0] STAT_DEC,
  output logic [31:0] STAT_ILL,
`endif
  otter_decode_queue_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef struct packed {
    logic [3:0] alu_fun;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [1:0] rf_wr_sel;
    logic       reg_we;
    logic       mem_we;
    logic       mem_rdch;
    logic [1:0] pc_sel;
    logic       illegal;
  } ctrl_t;

  ctrl_t      dec;
  logic       ill;
  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;

  always_comb begin
    dec = '0;
    ill = 1'b0;
    op  = bus.IN_IR[6:0];
    f3  = bus.IN_IR[14:12];
    f7  = bus.IN_IR[31:25];
    case (op)
      7'b0110111: begin
        dec.alu_fun = 4'b1001; dec.alu_srca = 1'b1; dec.rf_wr_sel = 2'b11; dec.reg_we = 1'b1;
      end
      7'b0010111: begin
        dec.alu_srca = 1'b1; dec.alu_srcb = 2'b11; dec.rf_wr_sel = 2'b11; dec.reg_we = 1'b1;
      end
      7'b1101111: begin
        dec.pc_sel = 2'b11; dec.rf_wr_sel = 2'b00; dec.reg_we = 1'b1;
      end
      7'b1100111: begin
        dec.pc_sel = 2'b01; dec.alu_srcb = 2'b01; dec.rf_wr_sel = 2'b00; dec.reg_we = 1'b1;
        ill = (f3 != 3'b000);
      end
      7'b1100011: begin
        dec.pc_sel = 2'b10;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      7'b0000011: begin
        dec.alu_srcb = 2'b01; dec.rf_wr_sel = 2'b10; dec.reg_we = 1'b1; dec.mem_rdch = 1'b1;
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'b0100011: begin
        dec.alu_srcb = 2'b10; dec.mem_we = 1'b1;
        ill = (f3 > 3'b010);
      end
      7'b0010011: begin
        dec.alu_srcb = 2'b01; dec.rf_wr_sel = 2'b11; dec.reg_we = 1'b1;
        // only the shift-right immediate uses IR[30] to pick arithmetic vs logical
        dec.alu_fun = (f3 == 3'b101) ? {bus.IN_IR[30], f3} : {1'b0, f3};
        if (f3 == 3'b001) ill = (f7 != 7'b0000000);
        if (f3 == 3'b101) ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      7'b0110011: begin
        dec.rf_wr_sel = 2'b11; dec.reg_we = 1'b1;
        dec.alu_fun = {bus.IN_IR[30], f3};
        ill = !((f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      default: ill = 1'b1;
    endcase
    if (bus.IN_IR[1:0] != 2'b11) ill = 1'b1;
    if (ill) dec = '0;
    dec.illegal = ill;
  end

  ctrl_t           ctrl_mem [DEPTH];
  logic [31:0]     ir_mem   [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop;

  // ready comes from registered count only, so a full queue never accepts on a pop cycle
  assign bus.IN_READY  = (count < FULL_CNT);
  assign bus.OUT_VALID = (count != '0);
  assign push = bus.IN_VALID && bus.IN_READY && !FLUSH;
  assign pop  = bus.OUT_VALID && bus.OUT_READY && !FLUSH;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (FLUSH) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      ctrl_mem[wr_ptr] <= dec;
      ir_mem[wr_ptr]   <= bus.IN_IR;
      pc_mem[wr_ptr]   <= bus.IN_PC;
    end
  end

  ctrl_t head;
  assign head          = ctrl_mem[rd_ptr];
  assign bus.ALU_FUN   = head.alu_fun;
  assign bus.ALU_SRCA  = head.alu_srca;
  assign bus.ALU_SRCB  = head.alu_srcb;
  assign bus.RF_WR_SEL = head.rf_wr_sel;
  assign bus.REG_WE    = head.reg_we;
  assign bus.MEM_WE    = head.mem_we;
  assign bus.MEM_RDEN  = head.mem_rdch;
  assign bus.PC_SEL    = head.pc_sel;
  assign bus.ILLEGAL   = head.illegal;
  assign bus.OUT_IR    = ir_mem[rd_ptr];
  assign bus.OUT_PC    = pc_mem[rd_ptr];

`ifdef DECODE_STATS_EN
  // counters survive FLUSH; only reset clears them
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STAT_DEC <= '0;
      STAT_ILL <= '0;
    end else if (push) begin
      STAT_DEC <= STAT_DEC + 32'd1;
      if (dec.illegal) STAT_ILL <= STAT_ILL + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_otter_decode_queue.sv
// Scoreboard bench for otter_decode_queue: driver queues hand-decoded expectations,
// a negedge monitor compares the head entry against them.
module tb_otter_decode_queue;
  logic CLK = 1'b0;
  logic RST_N;
  logic FLUSH;
`ifdef DECODE_STATS_EN
  logic [31:0] STAT_DEC, STAT_ILL;
`endif

  otter_decode_queue_if #(.XLEN(32)) q ();

  otter_decode_queue #(.XLEN(32), .DEPTH(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
`ifdef DECODE_STATS_EN
    .STAT_DEC(STAT_DEC), .STAT_ILL(STAT_ILL),
`endif
    .bus(q)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [14:0] ctrl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_push = 0;

  // {alu_fun, srca, srcb, wr_sel, reg_we, mem_we, mem_rden, pc_sel, illegal}
  function automatic logic [14:0] mk(input logic [3:0] af, input logic sa, input logic [1:0] sbs,
                                     input logic [1:0] wr, input logic rwe, input logic mwe,
                                     input logic rd, input logic [1:0] pcs, input logic ill);
    return {af, sa, sbs, wr, rwe, mwe, rd, pcs, ill};
  endfunction

  localparam logic [14:0] C_ILL = 15'h0001;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] ir, input logic [31:0] pc, input logic [14:0] ctrl);
    int n = 0;
    exp_t e;
    @(negedge CLK);
    q.IN_VALID = 1'b1; q.IN_IR = ir; q.IN_PC = pc;
    while (!q.IN_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!q.IN_READY) chk("push_timeout", 64'd0, 64'd1);
    else begin
      e.ir = ir; e.pc = pc; e.ctrl = ctrl;
      sb.push_back(e);
      n_push++;
    end
    @(posedge CLK);
    #1 q.IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  always @(negedge CLK) begin
    if (RST_N && q.OUT_VALID) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pc %0h ir %0h expected none", q.OUT_PC, q.OUT_IR);
      end else begin
        chk("ctrl", {q.ALU_FUN, q.ALU_SRCA, q.ALU_SRCB, q.RF_WR_SEL, q.REG_WE, q.MEM_WE,
                     q.MEM_RDEN, q.PC_SEL, q.ILLEGAL}, sb[0].ctrl);
        chk("out_ir", q.OUT_IR, sb[0].ir);
        chk("out_pc", q.OUT_PC, sb[0].pc);
        if (q.OUT_READY && !FLUSH) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; FLUSH = 1'b0;
    q.IN_VALID = 1'b0; q.IN_IR = '0; q.IN_PC = '0; q.OUT_READY = 1'b1;
    #12 chk("rst_out_valid", q.OUT_VALID, 0);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK);
    #1 chk("rst_in_ready", q.IN_READY, 1);
    chk("rst_out_valid2", q.OUT_VALID, 0);
`ifdef DECODE_STATS_EN
    chk("rst_stat_dec", STAT_DEC, 0);
`endif

    // basic decode, one-cycle latency
    push(32'h00500093, 32'h0, mk(4'b0000, 0, 2'b01, 2'b11, 1, 0, 0, 2'b00, 0));
    chk("lat_out_valid", q.OUT_VALID, 1);
    push(32'h4010D093, 32'h4, mk(4'b1101, 0, 2'b01, 2'b11, 1, 0, 0, 2'b00, 0));
    push(32'h402081B3, 32'h8, mk(4'b1000, 0, 2'b00, 2'b11, 1, 0, 0, 2'b00, 0));
    push(32'h0000006F, 32'hC, mk(4'b0000, 0, 2'b00, 2'b00, 1, 0, 0, 2'b11, 0));
    push(32'h00000000, 32'h10, C_ILL);
    push(32'h0200D093, 32'h14, C_ILL);
    drain();
`ifdef DECODE_STATS_EN
    chk("stat_ill", STAT_ILL, 2);
    chk("stat_dec", STAT_DEC, n_push);
`endif

    // remaining opcode classes
    push(32'h123450B7, 32'h18, mk(4'b1001, 1, 2'b00, 2'b11, 1, 0, 0, 2'b00, 0));
    push(32'h00000097, 32'h1C, mk(4'b0000, 1, 2'b11, 2'b11, 1, 0, 0, 2'b00, 0));
    push(32'h0000A083, 32'h20, mk(4'b0000, 0, 2'b01, 2'b10, 1, 0, 1, 2'b00, 0));
    push(32'h0010A023, 32'h24, mk(4'b0000, 0, 2'b10, 2'b00, 0, 1, 0, 2'b00, 0));
    push(32'h00000063, 32'h28, mk(4'b0000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b10, 0));
    push(32'h000080E7, 32'h2C, mk(4'b0000, 0, 2'b01, 2'b00, 1, 0, 0, 2'b01, 0));
    push(32'h000090E7, 32'h30, C_ILL);
    push(32'h0000B003, 32'h34, C_ILL);
    drain();

    // full queue backpressure, then drain in order
    @(negedge CLK) q.OUT_READY = 1'b0;
    push(32'h00100113, 32'h100, mk(4'b0000, 0, 2'b01, 2'b11, 1, 0, 0, 2'b00, 0));
    push(32'h00200193, 32'h104, mk(4'b0000, 0, 2'b01, 2'b11, 1, 0, 0, 2'b00, 0));
    chk("full_in_ready", q.IN_READY, 0);
    chk("full_out_valid", q.OUT_VALID, 1);
    fork
      push(32'h00300213, 32'h108, mk(4'b0000, 0, 2'b01, 2'b11, 1, 0, 0, 2'b00, 0));
      begin
        repeat (3) @(negedge CLK);
        q.OUT_READY = 1'b1;
      end
    join
    drain();

    // flush with input present drops both queue and input
    @(negedge CLK) q.OUT_READY = 1'b0;
    push(32'h00100113, 32'h200, mk(4'b0000, 0, 2'b01, 2'b11, 1, 0, 0, 2'b00, 0));
    push(32'h402081B3, 32'h204, mk(4'b1000, 0, 2'b00, 2'b11, 1, 0, 0, 2'b00, 0));
    @(negedge CLK);
    FLUSH = 1'b1; q.IN_VALID = 1'b1; q.IN_IR = 32'h0000006F; q.IN_PC = 32'h208;
    @(posedge CLK);
    #1 FLUSH = 1'b0; q.IN_VALID = 1'b0;
    sb.delete();
    chk("flush_out_valid", q.OUT_VALID, 0);
    chk("flush_in_ready", q.IN_READY, 1);
`ifdef DECODE_STATS_EN
    chk("flush_stat_dec", STAT_DEC, n_push);
`endif
    @(negedge CLK) q.OUT_READY = 1'b1;
    push(32'h00000097, 32'h300, mk(4'b0000, 1, 2'b11, 2'b11, 1, 0, 0, 2'b00, 0));
    drain();

    // asynchronous reset mid-cycle with entries queued
    @(negedge CLK) q.OUT_READY = 1'b0;
    push(32'h00100113, 32'h400, mk(4'b0000, 0, 2'b01, 2'b11, 1, 0, 0, 2'b00, 0));
    push(32'h00200193, 32'h404, mk(4'b0000, 0, 2'b01, 2'b11, 1, 0, 0, 2'b00, 0));
    #2 RST_N = 1'b0;
    #1 chk("async_rst_out_valid", q.OUT_VALID, 0);
    sb.delete();
    n_push = 0;
`ifdef DECODE_STATS_EN
    chk("async_rst_stat_dec", STAT_DEC, 0);
`endif
    @(negedge CLK) RST_N = 1'b1;
    @(negedge CLK) q.OUT_READY = 1'b1;
    chk("post_rst_in_ready", q.IN_READY, 1);
    push(32'h402081B3, 32'h500, mk(4'b1000, 0, 2'b00, 2'b11, 1, 0, 0, 2'b00, 0));
    chk("post_rst_out_valid", q.OUT_VALID, 1);
    drain();
`ifdef DECODE_STATS_EN
    chk("post_rst_stat_dec", STAT_DEC, 1);
`endif

    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
